// File: rtl/tl_timing_pkg.sv
// Shared constants for the interval timer bank: entry indices, default
// interval lengths and the countdown state encoding.
package tl_timing_pkg;

   localparam int BASE = 0;
   localparam int EXTD = 1;
   localparam int YELL = 2;

   localparam int BASE_DEFAULT = 6;
   localparam int EXTD_DEFAULT = 3;
   localparam int YELL_DEFAULT = 2;

   typedef enum logic {
      CD_IDLE,
      CD_RUN
   } cd_state_t;

   // A single-entry bank still needs a one-bit select.
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/interval_countdown.sv
// Loadable down-counter: counts ticks from the loaded value to zero and
// pulses expired for one cycle on completion. A load always restarts.
module interval_countdown
   import tl_timing_pkg::*;
#(
   parameter int VALUE_W = 4
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               load,
   input  logic [VALUE_W-1:0] load_value,
   input  logic               tick,
   output logic [VALUE_W-1:0] remaining,
   output logic               busy,
   output logic               expired
);

   cd_state_t          state, state_nxt;
   logic [VALUE_W-1:0] remaining_nxt;
   logic               expired_nxt;

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state     <= CD_IDLE;
         remaining <= '0;
         expired   <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         expired   <= expired_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      expired_nxt   = 1'b0;
      unique case (state)
         CD_IDLE: begin
            if (load) begin
               state_nxt     = CD_RUN;
               remaining_nxt = load_value;
            end
         end
         CD_RUN: begin
            if (load) begin
               remaining_nxt = load_value;
            end else if (tick) begin
               // A loaded zero finishes on its first tick instead of wrapping.
               if (remaining <= VALUE_W'(1)) begin
                  state_nxt     = CD_IDLE;
                  remaining_nxt = '0;
                  expired_nxt   = 1'b1;
               end else begin
                  remaining_nxt = remaining - VALUE_W'(1);
               end
            end
         end
         default: state_nxt = CD_IDLE;
      endcase
   end

   assign busy = (state == CD_RUN);

endmodule

// File: rtl/interval_timer_bank.sv
// Table of programmable interval lengths feeding one countdown; illegal
// selects latch a sticky error, and a bad write restores all defaults.
module interval_timer_bank
   import tl_timing_pkg::*;
#(
   parameter  int NUM_INTERVALS = 4,
   parameter  int VALUE_W       = 4,
   parameter  logic [NUM_INTERVALS-1:0][VALUE_W-1:0] DEFAULTS = {
      VALUE_W'(YELL_DEFAULT), VALUE_W'(YELL_DEFAULT),
      VALUE_W'(EXTD_DEFAULT), VALUE_W'(BASE_DEFAULT)},
   localparam int SEL_W         = sel_width(NUM_INTERVALS)
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               prog_valid,
   input  logic [SEL_W-1:0]   prog_sel,
   input  logic [VALUE_W-1:0] prog_value,
   input  logic               start,
   input  logic [SEL_W-1:0]   start_sel,
   input  logic               tick,
   output logic [VALUE_W-1:0] value,
   output logic [VALUE_W-1:0] remaining,
   output logic               busy,
   output logic               expired,
   output logic               err
);

   logic [VALUE_W-1:0] tbl_q [NUM_INTERVALS];
   logic               prog_ok;
   logic               start_ok;
   logic               start_load;
   logic [VALUE_W-1:0] start_value;

   assign prog_ok     = int'(prog_sel) < NUM_INTERVALS;
   assign start_ok    = int'(start_sel) < NUM_INTERVALS;
   assign start_load  = start && start_ok;
   // Read before the same-cycle write lands, so a start sees the old entry.
   assign start_value = start_ok ? tbl_q[start_sel] : '0;

   // NOTE: the table is a handful of flops, not RAM, so it can be reset to its defaults.
   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_INTERVALS; i++) tbl_q[i] <= DEFAULTS[i];
         value <= '0;
         err   <= 1'b0;
      end else begin
         if (prog_valid) begin
            if (prog_ok) begin
               tbl_q[prog_sel] <= (prog_value == '0) ? DEFAULTS[prog_sel] : prog_value;
            end else begin
               for (int i = 0; i < NUM_INTERVALS; i++) tbl_q[i] <= DEFAULTS[i];
               err <= 1'b1;
            end
         end
         if (start && !start_ok) err <= 1'b1;
         if (start_load) value <= start_value;
      end
   end

   interval_countdown #(
      .VALUE_W (VALUE_W)
   ) u_countdown (
      .clk        (clk),
      .Reset      (Reset),
      .load       (start_load),
      .load_value (start_value),
      .tick       (tick),
      .remaining  (remaining),
      .busy       (busy),
      .expired    (expired)
   );

endmodule

// File: tb/tb_interval_timer_bank.sv
// Scoreboard bench: the driver pushes the reference model's expected outputs
// per cycle, a separate monitor pops and compares after each rising edge.
module tb_interval_timer_bank;
   import tl_timing_pkg::*;

   localparam int N = 3;

   logic       clk = 1'b0;
   logic       Reset = 1'b0;
   logic       prog_valid = 1'b0;
   logic [1:0] prog_sel = '0;
   logic [3:0] prog_value = '0;
   logic       start = 1'b0;
   logic [1:0] start_sel = '0;
   logic       tick = 1'b0;
   logic [3:0] value;
   logic [3:0] remaining;
   logic       busy;
   logic       expired;
   logic       err;

   interval_timer_bank #(
      .NUM_INTERVALS (N),
      .VALUE_W       (4),
      .DEFAULTS      ({4'(YELL_DEFAULT), 4'(EXTD_DEFAULT), 4'(BASE_DEFAULT)})
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .prog_valid (prog_valid),
      .prog_sel   (prog_sel),
      .prog_value (prog_value),
      .start      (start),
      .start_sel  (start_sel),
      .tick       (tick),
      .value      (value),
      .remaining  (remaining),
      .busy       (busy),
      .expired    (expired),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] value;
      logic [3:0] remaining;
      logic       busy;
      logic       expired;
      logic       err;
   } obs_t;

   obs_t exp_q[$];
   int   tests_run = 0;
   int   failures  = 0;
   int   cycle     = 0;

   // Reference model: table contents and countdown as plain integers.
   int defaults[N] = '{6, 3, 2};
   int m_tbl[N];
   int m_value, m_rem;
   bit m_busy, m_exp, m_err;

   task automatic check(input string name, input obs_t act, input obs_t want);
      tests_run++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s cyc %0d: got value=%0d rem=%0d busy=%b exp=%b err=%b, want value=%0d rem=%0d busy=%b exp=%b err=%b",
                  name, cycle, act.value, act.remaining, act.busy, act.expired, act.err,
                  want.value, want.remaining, want.busy, want.expired, want.err);
      end
   endtask

   task automatic model_step();
      int old_tbl[N];
      old_tbl = m_tbl;
      if (Reset) begin
         m_tbl = defaults; m_value = 0; m_rem = 0;
         m_busy = 0; m_exp = 0; m_err = 0;
         return;
      end
      m_exp = 0;
      if (prog_valid) begin
         if (int'(prog_sel) < N) m_tbl[prog_sel] = (prog_value == 0) ? defaults[prog_sel] : int'(prog_value);
         else begin m_tbl = defaults; m_err = 1; end
      end
      if (start && int'(start_sel) < N) begin
         m_value = old_tbl[start_sel];
         m_rem   = old_tbl[start_sel];
         m_busy  = 1;
      end else begin
         if (start) m_err = 1;
         if (tick && m_busy) begin
            m_rem--;
            if (m_rem == 0) begin m_busy = 0; m_exp = 1; end
         end
      end
   endtask

   // Drives one cycle of inputs and queues the outputs expected after the next edge.
   task automatic step(input bit r, input bit pv, input int ps, input int pval,
                       input bit st, input int ss, input bit tk);
      obs_t e;
      @(posedge clk);
      #2;
      Reset = r; prog_valid = pv; prog_sel = 2'(ps); prog_value = 4'(pval);
      start = st; start_sel = 2'(ss); tick = tk;
      model_step();
      e = '{value: 4'(m_value), remaining: 4'(m_rem), busy: m_busy, expired: m_exp, err: m_err};
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic begin_run(input int sel);
      step(0, 0, 0, 0, 1, sel, 0);
   endtask

   task automatic write(input int sel, input int v);
      step(0, 1, sel, v, 0, 0, 0);
   endtask

   // Monitor: one observation per cycle, one cycle after its stimulus.
   initial begin
      obs_t act, want;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            act  = '{value: value, remaining: remaining, busy: busy, expired: expired, err: err};
            check("outputs", act, want);
         end
      end
   end

   initial begin
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 5, 1, 0, 1);
      idle(1);

      // Base interval from defaults.
      begin_run(BASE);
      ticks(6);
      idle(2);

      // Programmed value, then restore-to-default via zero.
      write(EXTD, 9);
      begin_run(EXTD);
      ticks(9);
      write(EXTD, 0);
      begin_run(EXTD);
      ticks(3);

      // Restart mid-run with no expiry for the aborted countdown.
      begin_run(BASE);
      ticks(2);
      begin_run(YELL);
      ticks(2);
      idle(1);

      // Start with tick together, then a write to the active entry mid-count.
      step(0, 0, 0, 0, 1, BASE, 1);
      ticks(2);
      step(0, 1, BASE, 1, 0, 0, 1);
      ticks(4);
      step(0, 0, 0, 0, 1, BASE, 1);
      ticks(6);

      // Start and write to the same entry in one cycle loads the old value.
      step(0, 1, YELL, 7, 1, YELL, 0);
      ticks(2);
      begin_run(YELL);
      ticks(7);

      // Illegal selects: defaults restored, err sticky, no run started.
      write(BASE, 11);
      write(3, 4);
      step(0, 0, 0, 0, 1, 3, 1);
      idle(2);
      begin_run(BASE);
      begin_run(YELL);
      idle(1);

      // Reset mid-countdown with remaining = 4.
      begin_run(BASE);
      ticks(2);
      step(1, 1, EXTD, 8, 1, EXTD, 1);
      idle(2);
      begin_run(EXTD);
      begin_run(BASE);
      begin_run(YELL);
      ticks(2);
      step(0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 79) == 0),
              ($urandom_range(0, 5) == 0),
              $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
              ($urandom_range(0, 9) == 0),
              $urandom_range(0, 3),
              ($urandom_range(0, 1) == 0));
      end
      idle(1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         tests_run++;
         failures++;
         $display("FAIL drain: %0d observations left unchecked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
